// File: rtl/seg_pkg.sv
// Shared character codes and segment patterns for the four-digit display.
// Producers build the disp word from these symbolic codes.
package seg_pkg;

    localparam logic [4:0] CH_BLANK = 5'd16;
    localparam logic [4:0] CH_H     = 5'd17;
    localparam logic [4:0] CH_L     = 5'd18;
    localparam logic [4:0] CH_P     = 5'd19;
    localparam logic [4:0] CH_DASH  = 5'd20;
    localparam logic [4:0] CH_R     = 5'd21;
    localparam logic [4:0] CH_O     = 5'd22;
    localparam logic [4:0] CH_N     = 5'd23;
    localparam logic [4:0] CH_T     = 5'd24;
    localparam logic [4:0] CH_U     = 5'd25;
    localparam logic [4:0] CH_Y     = 5'd26;

    // Bit order g,f,e,d,c,b,a; entry 31 listed first, entry 0 last.
    localparam logic [31:0][6:0] SEG_TABLE = {
        7'h00, 7'h00, 7'h00, 7'h00, 7'h00,          // 31..27 unused
        7'h6E, 7'h3E, 7'h78, 7'h54, 7'h5C,          // 26..22 y U t n o
        7'h50, 7'h40, 7'h73, 7'h38, 7'h76, 7'h00,   // 21..16 r - P L H blank
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77,   // F E d C b A
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66,   // 9 8 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F                  // 3 2 1 0
    };

endpackage

// File: rtl/seg_decode.sv
// Character code to logical (active-high) seven-segment pattern.
module seg_decode
    import seg_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] pat
);

    assign pat = SEG_TABLE[code];

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment scanner with a per-frame input latch
// and an anode blanking gap at the start of every digit slot.
module seg_scan
    import seg_pkg::*;
#(
    parameter int DIV        = 25000,
    parameter int BLANK      = 64,
    parameter int ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] disp,
    input  logic [3:0]  dp,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        frame
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt;
    logic [1:0]    digit;
    logic          primed;
    logic [19:0]   lat_disp;
    logic [3:0]    lat_dp;
    logic [3:0]    an_r;
    logic [7:0]    seg_r;
    logic          cnt_end;
    logic          load;
    logic [4:0]    code;
    logic [6:0]    pat;

    assign cnt_end = (cnt == CW'(DIV - 1));
    assign load    = (cnt_end && (digit == 2'd3)) || !primed;

    always_comb begin
        code = lat_disp[4:0];
        case (digit)
            2'd0: code = lat_disp[4:0];
            2'd1: code = lat_disp[9:5];
            2'd2: code = lat_disp[14:10];
            2'd3: code = lat_disp[19:15];
            default: code = lat_disp[4:0];
        endcase
    end

    seg_decode u_decode (
        .code (code),
        .pat  (pat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            digit    <= 2'd0;
            primed   <= 1'b0;
            frame    <= 1'b0;
            lat_disp <= {4{CH_BLANK}};
            lat_dp   <= 4'b0;
            an_r     <= 4'b0;
            seg_r    <= 8'b0;
        end else begin
            cnt    <= cnt_end ? '0 : cnt + CW'(1);
            primed <= 1'b1;
            frame  <= load;
            if (cnt_end) begin
                digit <= digit + 2'd1;
            end
            // Latch only at the frame boundary so a frame never mixes old and new digits.
            if (load) begin
                lat_disp <= disp;
                lat_dp   <= dp;
            end
            an_r  <= (cnt < CW'(BLANK)) ? 4'b0000 : (4'b0001 << digit);
            seg_r <= {lat_dp[digit], pat};
        end
    end

    assign an  = (ACTIVE_LOW != 0) ? ~an_r  : an_r;
    assign seg = (ACTIVE_LOW != 0) ? ~seg_r : seg_r;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: an active-high and an active-low instance
// run side by side from the same stimulus.
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] disp = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  an_h, an_l;
    logic [7:0]  seg_h, seg_l;
    logic        frame_h, frame_l;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       fr;
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    seg_scan #(.DIV(4), .BLANK(1), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .disp(disp), .dp(dp),
        .an(an_h), .seg(seg_h), .frame(frame_h)
    );

    seg_scan #(.DIV(4), .BLANK(1), .ACTIVE_LOW(1)) dut_n (
        .clk(clk), .rst(rst), .disp(disp), .dp(dp),
        .an(an_l), .seg(seg_l), .frame(frame_l)
    );

    function automatic logic [6:0] pat(input logic [4:0] c);
        case (c)
            5'd0:  pat = 7'h3F;  5'd1:  pat = 7'h06;  5'd2:  pat = 7'h5B;
            5'd3:  pat = 7'h4F;  5'd4:  pat = 7'h66;  5'd5:  pat = 7'h6D;
            5'd6:  pat = 7'h7D;  5'd7:  pat = 7'h07;  5'd8:  pat = 7'h7F;
            5'd9:  pat = 7'h6F;  5'd10: pat = 7'h77;  5'd11: pat = 7'h7C;
            5'd12: pat = 7'h39;  5'd13: pat = 7'h5E;  5'd14: pat = 7'h79;
            5'd15: pat = 7'h71;  5'd17: pat = 7'h76;  5'd18: pat = 7'h38;
            5'd19: pat = 7'h73;  5'd20: pat = 7'h40;  5'd21: pat = 7'h50;
            5'd22: pat = 7'h5C;  5'd23: pat = 7'h54;  5'd24: pat = 7'h78;
            5'd25: pat = 7'h3E;  5'd26: pat = 7'h6E;
            default: pat = 7'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected outputs for one cycle of a digit slot, given the latched frame.
    task automatic push_cycle(input int d, input int c, input logic [19:0] ld,
                              input logic [3:0] ldp, input logic fr);
        exp_t e;
        logic [4:0] code;
        code  = ld[5*d +: 5];
        e.fr  = fr;
        e.an  = (c < 1) ? 4'b0000 : (4'b0001 << d);
        e.seg = {ldp[d], pat(code)};
        q.push_back(e);
    endtask

    task automatic push_frame(input logic [19:0] ld, input logic [3:0] ldp, input int first_c);
        for (int d = 0; d < 4; d++)
            for (int c = 0; c < 4; c++)
                if (!(d == 0 && c < first_c))
                    push_cycle(d, c, ld, ldp, (d == 3 && c == 3));
    endtask

    task automatic push_release();
        exp_t e;
        e.fr = 1'b1; e.an = 4'b0; e.seg = 8'h00;
        q.push_back(e);
    endtask

    task automatic step(input int n, input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                chk({tag, "_underflow"}, 8'd1, 8'd0);
            end else begin
                e = q.pop_front();
                chk({tag, "_frame"},   {7'b0, frame_h}, {7'b0, e.fr});
                chk({tag, "_an"},      {4'b0, an_h},    {4'b0, e.an});
                chk({tag, "_seg"},     seg_h,           e.seg);
                chk({tag, "_frame_n"}, {7'b0, frame_l}, {7'b0, e.fr});
                chk({tag, "_an_n"},    {4'b0, an_l},    {4'b0, ~e.an});
                chk({tag, "_seg_n"},   seg_l,           ~e.seg);
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_an"},    {4'b0, an_h},    8'h00);
        chk({tag, "_seg"},   seg_h,           8'h00);
        chk({tag, "_frame"}, {7'b0, frame_h}, 8'h00);
        chk({tag, "_an_n"},  {4'b0, an_l},    8'h0F);
        chk({tag, "_seg_n"}, seg_l,           8'hFF);
        chk({tag, "_digit"}, {6'b0, dut.digit}, 8'h00);
        chk({tag, "_cnt"},   {6'b0, dut.cnt},   8'h00);
    endtask

    localparam logic [19:0] D1 = {5'd1, 5'd2, 5'd3, 5'd4};
    localparam logic [19:0] DB = {4{5'd16}};
    localparam logic [19:0] D4 = {5'd16, 5'd21, 5'd17, 5'd27};
    localparam logic [19:0] D5 = {5'd8, 5'd0, 5'd15, 5'd10};

    initial begin
        rst  = 1'b1;
        disp = D1;
        dp   = 4'b0000;
        repeat (3) @(negedge clk);
        chk_reset("reset");

        // Release: load on the first edge, then the first (short) frame.
        rst = 1'b0;
        push_release();
        push_frame(D1, 4'b0000, 1);
        step(16, "first_frame");

        push_frame(D1, 4'b0000, 0);
        step(16, "steady");

        // Mid-frame change during digit 1 stays hidden until the next load.
        push_frame(D1, 4'b0000, 0);
        step(6, "pre_change");
        disp = DB;
        step(10, "old_digits");

        push_frame(DB, 4'b0000, 0);
        step(2, "blank_frame");
        disp = D4;
        dp   = 4'b0100;
        step(14, "blank_frame");

        push_frame(D4, 4'b0100, 0);
        step(10, "codes");

        // Reset while digit 2 is lit.
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        chk_reset("mid_reset");
        rst = 1'b0;
        push_release();
        push_frame(D4, 4'b0100, 1);
        step(15, "reload");
        // Change coincides with the load edge and must be captured.
        disp = D5;
        dp   = 4'b0000;
        step(1, "reload");
        push_frame(D5, 4'b0000, 0);
        step(16, "edge_capture");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed 4-digit seven-segment driver that consumes the 20-bit `disp` word produced by the board manager and drives the physical anode and segment pins. It is the display-side end of the manager's `disp` interface. It latches `disp` once per refresh frame so digits never tear mid-frame, scans one digit at a time, and inserts a short anode blanking gap at each digit change to suppress ghosting.

## Interface
Parameters:
- `DIV`, 25000: clock cycles per digit slot; must be at least 2.
- `BLANK`, 64: cycles at the start of each slot with all anodes off; must be less than `DIV`.
- `ACTIVE_LOW`, 1: when 1, `an` and `seg` are inverted at the pins (common-anode board).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `disp` in 20: four 5-bit character codes; digit k = `disp[5k+4:5k]`; digit 0 is rightmost.
- `dp` in 4: decimal point per digit; bit k belongs to digit k.
- `an` out 4: digit enables; bit k drives digit k.
- `seg` out 8: `seg[7]` = dp, `seg[6:0]` = g,f,e,d,c,b,a.
- `frame` out 1: one-cycle pulse on the cycle the frame latch loads.

## Operation
Character codes (logical, active-high segment patterns):
- 0–15: hex digits 0–F. Examples: 0 = 7'h3F, 1 = 7'h06, 8 = 7'h7F, A = 7'h77, F = 7'h71.
- 16: blank = 7'h00.
- 17: H = 7'h76
- 18: L = 7'h38
- 19: P = 7'h73
- 20: dash = 7'h40
- 21: r = 7'h50
- 22: o = 7'h5C
- 23: n = 7'h54
- 24: t = 7'h78
- 25: U = 7'h3E
- 26: y = 7'h6E
- 27–31: blank.

Registers:
- `cnt`: 0..DIV-1, increments every cycle and wraps at `DIV-1`.
- `digit`: 2-bit, increments when `cnt == DIV-1`; wraps from 3 to 0.
- `lat_disp`/`lat_dp`: frame latch for `disp` and `dp`.
- `primed`: flag that forces a latch load on the first cycle out of reset.

Latch load rule. `lat_disp`/`lat_dp` load from `disp`/`dp` when either:
- `cnt == DIV-1` and `digit == 3`, or
- `primed == 0` (the first cycle after reset).

`frame` pulses on exactly those load cycles. Inputs are sampled only on load cycles; changes to `disp` at any other time are invisible until the next frame.

Output rule:
- During the blanking window (`cnt < BLANK`): `an = 0`.
- Otherwise: `an = 1 << digit`.
- `seg` = `{lat_dp[digit], pattern(lat_disp field digit)}`.
- `an` and `seg` are registered, so they follow `cnt`/`digit` with 1 cycle of latency.
- Polarity inversion per `ACTIVE_LOW` is applied after the register.

Reset values (logical, before polarity inversion):
- `cnt = 0`, `digit = 0`, `primed = 0`, `frame = 0`.
- `lat_disp = {4{5'd16}}` (all blank), `lat_dp = 0`.
- `an = 0`, `seg = 0`.
- Pin level is therefore all-off: with `ACTIVE_LOW = 1`, `an = 4'hF` and `seg = 8'hFF`.

Reset asserted mid-frame: on the next edge all state returns to the reset values; no partial digit completes.

## Timing
- Latency from the latch load to the corresponding digit lighting: `BLANK + 1` cycles into that digit's slot.
- Full frame period: `4*DIV` cycles. `frame` pulses exactly once per period in steady state.
- Out of reset:
  - cycle 0 after deassertion: latch load and `frame` pulse.
  - digit 0 becomes visible at cycle `BLANK + 1`.
- Simultaneous events: a `disp` change coinciding with a load cycle is captured, because the latch takes the value present at the clock edge.

## Structure
- Package `seg_pkg`:
  - character code constants (`CH_BLANK = 16`, `CH_H = 17`, …).
  - the 32-entry segment pattern table.
  - shared with the manager and editor so producers use symbolic codes.
- Sub-module `seg_decode`: combinational, 5-bit code to 7-bit pattern, built from the `seg_pkg` table.
- The top instantiates one `seg_decode` on the muxed field selected by `digit`.

## Test plan
Bench parameters: `DIV = 4`, `BLANK = 1`, `ACTIVE_LOW = 0` unless stated otherwise.
1. Reset hold, then release with `disp` = {1,2,3,4} (digit3..0), `dp = 0`.
   - `frame` pulses on the first cycle after release.
   - Digit 0 then shows `an = 0001`, `seg = 8'h66` ("4") in cycles 2–4; digit 1 shows `an = 0010`, `seg = 8'h4F` ("3").
2. Steady state: `frame` pulses every 16 cycles, never twice in one frame. The `an` sequence is 0000, 0001×3, 0000, 0010×3, … .
3. Change `disp` mid-frame (digit 1 slot) to all 16 (blank).
   - The old digits 2 and 3 still display.
   - All digits show `seg = 0` only after the next `frame` pulse.
4. Codes 17, 21, 27 with `dp = 4'b0100` produce `seg`:
   - 8'h76 for 17.
   - 8'hD0 for 21 on digit 2 (dp set).
   - 8'h00 for 27.
5. Assert `rst` while digit 2 is lit: the next cycle gives `an = 0`, `seg = 0`, `digit = 0`; after release, latch reload and `frame` pulse.
6. With `ACTIVE_LOW = 1`: reset gives `an = 4'hF`, `seg = 8'hFF`; the digit-0 "4" appears as `an = 4'hE`, `seg = 8'h99`.
